// File: rtl/mux_arbiter2_if.sv
// Bundle of request, data and registered output signals for mux_arbiter2.
interface mux_arbiter2_if #(
  parameter int W = 1
);
  logic [1:0]   req;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [1:0]   gnt;
  logic         sel;
  logic [W-1:0] y;
  logic         y_valid;

  modport master (
    output req, d0, d1,
    input  gnt, sel, y, y_valid
  );

  modport slave (
    input  req, d0, d1,
    output gnt, sel, y, y_valid
  );
endinterface

// File: rtl/mux_arbiter2.sv
// Round-robin arbiter for a shared 2:1 mux: one-hot grant with a bounded
// hold time per requester, registered select and registered mux output.
module mux_arbiter2 #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          reset,
  mux_arbiter2_if.slave bus
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [W-1:0]  y_q;
  logic          y_valid_q;

  logic          enter;
  logic          enter_k;
  logic          cur_k;

  // Next state: every (re-)entry to a grant resets cnt and records last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    enter   = 1'b0;
    enter_k = 1'b0;
    cur_k   = (state_q == G1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        case (bus.req)
          2'b01:   begin enter = 1'b1; enter_k = 1'b0;    end
          2'b10:   begin enter = 1'b1; enter_k = 1'b1;    end
          2'b11:   begin enter = 1'b1; enter_k = ~last_q; end
          default: ;
        endcase
      end
      G0, G1: begin
        if (!bus.req[cur_k] || cnt_q == HOLD_LAST) begin
          if (bus.req[~cur_k]) begin
            enter   = 1'b1;
            enter_k = ~cur_k;
          end else if (bus.req[cur_k]) begin
            enter   = 1'b1;
            enter_k = cur_k;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enter) begin
      state_d = enter_k ? G1 : G0;
      last_d  = enter_k;
      cnt_d   = '0;
      sel_d   = enter_k;
    end
    case (state_d)
      G0:      gnt_d = 2'b01;
      G1:      gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  // Arbitration state and registered grant/select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // Data path: registers the data of the requester granted last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      if (gnt_q[1])      y_q <= bus.d1;
      else if (gnt_q[0]) y_q <= bus.d0;
      y_valid_q <= |gnt_q;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Self-checking bench for mux_arbiter2: a behavioural ownership model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mux_arbiter2;

  localparam int W  = 4;
  localparam int MH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mux_arbiter2_if #(.W(W)) bus ();

  mux_arbiter2 #(.W(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the output, for how many cycles so far,
  // and who was served most recently.
  int           m_owner  = -1;
  int           m_tenure = 0;
  int           m_last   = 1;
  logic [W-1:0] m_y      = '0;
  logic         m_v      = 1'b0;
  logic         m_sel    = 1'b0;

  task automatic m_give(input int k);
    m_owner  = k;
    m_tenure = 1;
    m_last   = k;
    m_sel    = (k == 1);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_owner = -1; m_tenure = 0; m_last = 1;
        m_y = '0; m_v = 1'b0; m_sel = 1'b0;
      end else begin
        if (m_owner == 1)      m_y = bus.d1;
        else if (m_owner == 0) m_y = bus.d0;
        m_v = (m_owner != -1);
        if (m_owner == -1) begin
          if (bus.req == 2'b11)      m_give(1 - m_last);
          else if (bus.req == 2'b01) m_give(0);
          else if (bus.req == 2'b10) m_give(1);
        end else if (bus.req[m_owner] && m_tenure < MH) begin
          m_tenure++;
        end else if (bus.req[1 - m_owner]) begin
          m_give(1 - m_owner);
        end else if (bus.req[m_owner]) begin
          m_give(m_owner);
        end else begin
          m_owner = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_gnt", 32'(bus.gnt),
            32'(m_owner == 1 ? 2'b10 : (m_owner == 0 ? 2'b01 : 2'b00)));
      check("model_sel", 32'(bus.sel), 32'(m_sel));
      check("model_y", 32'(bus.y), 32'(m_y));
      check("model_y_valid", 32'(bus.y_valid), 32'(m_v));
      check("gnt_not_11", 32'(bus.gnt == 2'b11), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_idle();
    bus.req = 2'b00;
    repeat (3) tick();
  endtask

  int n0, n1;

  initial begin
    reset   = 1'b0;
    bus.req = 2'b11;
    bus.d0  = '0;
    bus.d1  = '0;

    // 1: reset held with req=11
    repeat (3) begin
      tick();
      check("t1_gnt", 32'(bus.gnt), 32'h0);
      check("t1_y_valid", 32'(bus.y_valid), 32'h0);
      check("t1_y", 32'(bus.y), 32'h0);
    end
    bus.req = 2'b00;
    reset   = 1'b1;
    tick();

    // 2: single request, one-cycle data latency, release
    bus.req = 2'b01;
    bus.d0  = 4'h1;
    bus.d1  = 4'hE;
    tick();
    check("t2_gnt", 32'(bus.gnt), 32'h1);
    check("t2_sel", 32'(bus.sel), 32'h0);
    check("t2_valid_early", 32'(bus.y_valid), 32'h0);
    tick();
    check("t2_y", 32'(bus.y), 32'h1);
    check("t2_y_valid", 32'(bus.y_valid), 32'h1);
    bus.req = 2'b00;
    tick();
    check("t2_gnt_drop", 32'(bus.gnt), 32'h0);
    check("t2_valid_tail", 32'(bus.y_valid), 32'h1);
    tick();
    check("t2_valid_off", 32'(bus.y_valid), 32'h0);
    check("t2_y_hold", 32'(bus.y), 32'h1);
    check("t2_sel_hold", 32'(bus.sel), 32'h0);

    // 3: fresh reset, continuous contention alternates every 4 cycles
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    bus.req = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int i = 1; i <= 32; i++) begin
      bus.d0 = 4'(i);
      bus.d1 = 4'(15 - i);
      tick();
      if (bus.gnt == 2'b01) n0++;
      if (bus.gnt == 2'b10) n1++;
      if (i == 1) check("t3_first", 32'(bus.gnt), 32'h1);
      if (i == 4) check("t3_g0_end", 32'(bus.gnt), 32'h1);
      if (i == 5) check("t3_switch", 32'(bus.gnt), 32'h2);
      if (i == 9) check("t3_back", 32'(bus.gnt), 32'h1);
    end
    check("t3_count0", 32'(n0), 32'd16);
    check("t3_count1", 32'(n1), 32'd16);
    go_idle();

    // 4: G0 drops while req1 rises -> direct handover
    bus.req = 2'b01;
    tick();
    tick();
    check("t4_g0", 32'(bus.gnt), 32'h1);
    bus.req = 2'b10;
    tick();
    check("t4_direct_g1", 32'(bus.gnt), 32'h2);
    check("t4_sel", 32'(bus.sel), 32'h1);
    go_idle();

    // 5: lone requester holds through hold-limit re-grants
    bus.req = 2'b01;
    n0 = 0;
    for (int i = 0; i < 12; i++) begin
      bus.d0 = 4'(i + 3);
      tick();
      if (bus.gnt == 2'b01) n0++;
    end
    check("t5_continuous", 32'(n0), 32'd12);
    check("t5_valid", 32'(bus.y_valid), 32'h1);
    go_idle();

    // 6: asynchronous reset mid-grant, then restart favouring req0
    bus.req = 2'b10;
    bus.d1  = 4'hA;
    tick();
    tick();
    check("t6_g1", 32'(bus.gnt), 32'h2);
    check("t6_y", 32'(bus.y), 32'hA);
    check("t6_valid", 32'(bus.y_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    check("t6_rst_sel", 32'(bus.sel), 32'h0);
    check("t6_rst_y", 32'(bus.y), 32'h0);
    check("t6_rst_valid", 32'(bus.y_valid), 32'h0);
    #1 reset = 1'b1;
    bus.req = 2'b11;
    tick();
    check("t6_restart_g0", 32'(bus.gnt), 32'h1);
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
